mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the single-port data/instruction SRAM between the fetch stage and the memory stage. Fetch issues reads; the memory stage issues loads and stores using the MEM_R/MEM_W strobes from the control unit. The block arbitrates between the two, sequences a fixed-latency SRAM access, and returns one-cycle ready pulses. The pipeline uses those pulses as its freeze release.

## Interface
- WAIT_CYCLES, 3, SRAM access duration in cycles (≥1)
- ADDR_W, 32, address width
- DATA_W, 32, data width

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- if_req  in  1  fetch read request, level, held until if_ready
- if_addr  in  ADDR_W  fetch address, stable while if_req
- if_ready  out  1  one-cycle pulse: fetch access done
- if_rdata  out  DATA_W  fetch data, valid when if_ready
- MEM_R  in  1  load request, level, held until mem_ready
- MEM_W  in  1  store request, level, held until mem_ready
- mem_addr  in  ADDR_W  load/store address
- mem_wdata  in  DATA_W  store data
- mem_ready  out  1  one-cycle pulse: load/store done
- mem_rdata  out  DATA_W  load data, valid when mem_ready after MEM_R
- sram_en  out  1  SRAM access active
- sram_we  out  1  SRAM write enable
- sram_addr  out  ADDR_W  SRAM address
- sram_wdata  out  DATA_W  SRAM write data
- sram_rdata  in  DATA_W  SRAM read data, valid on last access cycle

## Operation
- FSM states: IDLE, ACCESS, RESP.
- **IDLE:**
  - Samples requests.
  - Data request means MEM_R|MEM_W.
  - Grant goes to data unless both requesters are pending and last_grant==DATA; then fetch wins. This alternation prevents starvation.
  - On grant, latch into output registers: sram_addr, sram_wdata, sram_we (MEM_W for data, 0 for fetch), grant owner, last_grant.
  - Set cnt=0 and move to ACCESS.
  - With no request, stay in IDLE.
- **ACCESS:**
  - sram_en=1; sram_we as latched.
  - cnt increments each cycle.
  - On cnt==WAIT_CYCLES-1: capture sram_rdata into the owner's rdata register (writes leave rdata unchanged), drop sram_en/sram_we, and move to RESP.
- **RESP:**
  - The owner's ready is high for exactly this cycle.
  - Next state is always IDLE. Requests are never sampled in RESP, so the requester's stale level is not regranted.
- MEM_R and MEM_W both high: treated as a store (MEM_W wins).
- Fetch cancel: if if_req drops during ACCESS (branch flush), the access still completes. In RESP, if_ready is suppressed and if_rdata is not updated.
- Data requests are never cancelled.
- cnt width: $clog2(WAIT_CYCLES+1). No wrap occurs; cnt is cleared on every grant.

## Timing
- Request first seen in IDLE at cycle 0:
  - sram_en is high in cycles 1..WAIT_CYCLES.
  - ready is high in cycle WAIT_CYCLES+1.
  - IDLE is reached in cycle WAIT_CYCLES+2.
- Throughput: one access per WAIT_CYCLES+2 cycles.
- All outputs are registered. No combinational path from inputs to outputs.
- rdata registers hold their value until the next read by the same owner.
- Reset values: state=IDLE, cnt=0, last_grant=FETCH.
  - All outputs are 0: if_ready, mem_ready, if_rdata, mem_rdata, sram_en, sram_we, sram_addr, sram_wdata.
- Reset mid-access: sram_en/sram_we are low in the cycle after the reset edge and no ready pulse is produced. The partial write is not retried.

## Structure
- constants.h gains:
  - state encodings `ARB_IDLE, `ARB_ACCESS, `ARB_RESP
  - grant encodings `GNT_FETCH, `GNT_DATA
  - default `SRAM_WAIT_CYCLES
- One module, no sub-modules. The wait counter is inline.

## Test plan
- Reset: hold rst 2 cycles with if_req=MEM_W=1 -> all outputs 0, no sram_en. Release -> data granted first (last_grant reset to FETCH, MEM_W pending).
- Load, WAIT_CYCLES=3: MEM_R, mem_addr=0x40 at cycle 0; sram_rdata=0xDEADBEEF in cycle 3 -> sram_en cycles 1-3 with sram_addr=0x40, sram_we=0; mem_ready cycle 4 with mem_rdata=0xDEADBEEF.
- Store: MEM_W, mem_addr=0x80, mem_wdata=0x12345678 -> sram_we=sram_en=1 cycles 1-3 with those values; mem_ready cycle 4; mem_rdata unchanged.
- Contention: if_req and MEM_R together -> data first (ready cycle 4), fetch next (if_ready cycle 9). Both again -> fetch then data alternation.
- Flush: if_req dropped in cycle 2 of a fetch -> access completes, no if_ready, if_rdata unchanged, IDLE in cycle 5.
- Reset at cycle 2 of store -> sram_we=0 in cycle 3, no mem_ready, state IDLE.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: state/grant encodings and default SRAM latency for the memory port arbiter
package mem_port_arbiter_pkg;
  typedef enum logic [1:0] {ARB_IDLE, ARB_ACCESS, ARB_RESP} arb_state_t;
  typedef enum logic {GNT_FETCH, GNT_DATA} gnt_t;
  localparam int SRAM_WAIT_CYCLES = 3;
endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency SRAM between fetch reads and data loads/stores with alternating priority
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int WAIT_CYCLES = SRAM_WAIT_CYCLES,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              MEM_R,
  input  logic              MEM_W,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              mem_ready,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              sram_en,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);
  localparam int CW = $clog2(WAIT_CYCLES + 1);
  arb_state_t state, next_state;
  gnt_t last_grant, owner;
  logic [CW-1:0] cnt;
  logic data_req, pick_data, grant, last_beat;
  always_comb begin
    data_req   = MEM_R | MEM_W;
    pick_data  = data_req && !(if_req && last_grant == GNT_DATA);
    grant      = state == ARB_IDLE && (if_req || data_req);
    last_beat  = state == ARB_ACCESS && cnt == CW'(WAIT_CYCLES - 1);
    next_state = grant ? ARB_ACCESS :
                 state == ARB_ACCESS ? (last_beat ? ARB_RESP : ARB_ACCESS) : ARB_IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) state <= ARB_IDLE;
    else     state <= next_state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      last_grant <= GNT_FETCH;
      owner      <= GNT_FETCH;
      if_ready   <= 1'b0;
      mem_ready  <= 1'b0;
      if_rdata   <= '0;
      mem_rdata  <= '0;
      sram_en    <= 1'b0;
      sram_we    <= 1'b0;
      sram_addr  <= '0;
      sram_wdata <= '0;
    end else begin
      if_ready  <= 1'b0;
      mem_ready <= 1'b0;
      if (grant) begin
        owner      <= pick_data ? GNT_DATA : GNT_FETCH;
        last_grant <= pick_data ? GNT_DATA : GNT_FETCH;
        cnt        <= '0;
        sram_en    <= 1'b1;
        sram_we    <= pick_data & MEM_W;
        sram_addr  <= pick_data ? mem_addr : if_addr;
        sram_wdata <= pick_data ? mem_wdata : '0;
      end
      if (state == ARB_ACCESS) cnt <= cnt + CW'(1);
      if (last_beat) begin
        sram_en <= 1'b0;
        sram_we <= 1'b0;
        if (owner == GNT_DATA) begin
          mem_ready <= 1'b1;
          if (!sram_we) mem_rdata <= sram_rdata;
        end else if (if_req) begin
          if_ready <= 1'b1;
          if_rdata <= sram_rdata;
        end
      end
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;
  localparam int W = 3;
  typedef struct { logic data; logic [31:0] rdata; int cyc; } rsp_t;
  typedef struct { int cyc; logic we; logic [31:0] addr; logic [31:0] wdata; } acc_t;
  logic clk = 0, rst = 1;
  logic if_req = 0, MEM_R = 0, MEM_W = 0;
  logic [31:0] if_addr = 0, mem_addr = 0, mem_wdata = 0, sram_rdata = 0;
  logic if_ready, mem_ready, sram_en, sram_we;
  logic [31:0] if_rdata, mem_rdata, sram_addr, sram_wdata;
  int cyc = 0, vectors = 0, miscompares = 0, run = 0, c0 = 0;
  rsp_t exp_rsp[$];
  acc_t exp_acc[$];
  mem_port_arbiter #(.WAIT_CYCLES(W), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready),
    .if_rdata(if_rdata), .MEM_R(MEM_R), .MEM_W(MEM_W), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [31:0] f(input logic [31:0] a);
    return a == 32'h40 ? 32'hDEADBEEF : a ^ 32'h5A5A_0000;
  endfunction
  initial forever begin
    @(posedge clk);
    #1;
    run = sram_en ? run + 1 : 0;
    sram_rdata = run == W ? f(sram_addr) : 32'hBAD0_0000 + run;
  end
  initial forever begin
    @(negedge clk);
    if (sram_we && !sram_en) begin
      vectors++; miscompares++;
      $display("FAIL we_without_en cyc=%0d got we=1 en=0 want we=0", cyc);
    end
    if (sram_en) begin
      vectors++;
      if (exp_acc.size() == 0) begin
        miscompares++;
        $display("FAIL sram_unexpected cyc=%0d got en=1 addr=%h want en=0", cyc, sram_addr);
      end else begin
        acc_t e;
        e = exp_acc.pop_front();
        if (e.cyc != cyc || e.we != sram_we || e.addr != sram_addr || (e.we && e.wdata != sram_wdata)) begin
          miscompares++;
          $display("FAIL sram_access got cyc=%0d we=%b addr=%h wdata=%h want cyc=%0d we=%b addr=%h wdata=%h",
                   cyc, sram_we, sram_addr, sram_wdata, e.cyc, e.we, e.addr, e.wdata);
        end
      end
    end
    if (if_ready || mem_ready) begin
      vectors++;
      if (exp_rsp.size() == 0 || (if_ready && mem_ready)) begin
        miscompares++;
        $display("FAIL ready_unexpected cyc=%0d got if_ready=%b mem_ready=%b want none", cyc, if_ready, mem_ready);
      end else begin
        rsp_t e;
        logic [31:0] got;
        e = exp_rsp.pop_front();
        got = mem_ready ? mem_rdata : if_rdata;
        if (e.data != mem_ready || e.rdata != got || e.cyc != cyc) begin
          miscompares++;
          $display("FAIL ready got cyc=%0d data=%b rdata=%h want cyc=%0d data=%b rdata=%h",
                   cyc, mem_ready, got, e.cyc, e.data, e.rdata);
        end
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic expect_acc(input int start, input logic data, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] rdata, input int n_en, input logic rsp);
    for (int i = 1; i <= n_en; i++) exp_acc.push_back('{start + i, we, addr, wdata});
    if (rsp) exp_rsp.push_back('{data, rdata, start + W + 1});
  endtask
  task automatic drain();
    int n = 0;
    while ((if_req || MEM_R || MEM_W) && n < 40) begin
      tick();
      n++;
      if (mem_ready) begin MEM_R = 0; MEM_W = 0; end
      if (if_ready) if_req = 0;
    end
    if (if_req || MEM_R || MEM_W) begin
      vectors++; miscompares++;
      $display("FAIL drain_timeout cyc=%0d got pending if=%b r=%b w=%b want none", cyc, if_req, MEM_R, MEM_W);
      if_req = 0; MEM_R = 0; MEM_W = 0;
    end
    tick();
  endtask
  task automatic check_zero(input string name);
    vectors++;
    if ({if_ready, mem_ready, sram_en, sram_we} != 0 || if_rdata != 0 || mem_rdata != 0 || sram_addr != 0 || sram_wdata != 0) begin
      miscompares++;
      $display("FAIL %s got rdy=%b/%b en=%b we=%b ifd=%h memd=%h addr=%h wd=%h want all 0",
               name, if_ready, mem_ready, sram_en, sram_we, if_rdata, mem_rdata, sram_addr, sram_wdata);
    end
  endtask
  initial begin
    if_req = 1; if_addr = 32'h100; MEM_W = 1; mem_addr = 32'h80; mem_wdata = 32'h12345678;
    tick(); check_zero("reset_c1");
    tick(); check_zero("reset_c2");
    rst = 0; c0 = cyc;
    expect_acc(c0, 1, 1, 32'h80, 32'h12345678, 32'h0, W, 1);
    expect_acc(c0 + 5, 0, 0, 32'h100, 0, f(32'h100), W, 1);
    drain();
    MEM_R = 1; mem_addr = 32'h40; c0 = cyc;
    expect_acc(c0, 1, 0, 32'h40, 0, 32'hDEADBEEF, W, 1);
    drain();
    MEM_W = 1; mem_addr = 32'h80; mem_wdata = 32'h12345678; c0 = cyc;
    expect_acc(c0, 1, 1, 32'h80, 32'h12345678, 32'hDEADBEEF, W, 1);
    drain();
    if_req = 1; if_addr = 32'h204; MEM_R = 1; mem_addr = 32'h48; c0 = cyc;
    expect_acc(c0, 0, 0, 32'h204, 0, f(32'h204), W, 1);
    expect_acc(c0 + 5, 1, 0, 32'h48, 0, f(32'h48), W, 1);
    drain();
    if_req = 1; if_addr = 32'h104; c0 = cyc;
    expect_acc(c0, 0, 0, 32'h104, 0, f(32'h104), W, 1);
    drain();
    if_req = 1; if_addr = 32'h200; MEM_R = 1; mem_addr = 32'h44; c0 = cyc;
    expect_acc(c0, 1, 0, 32'h44, 0, f(32'h44), W, 1);
    expect_acc(c0 + 5, 0, 0, 32'h200, 0, f(32'h200), W, 1);
    drain();
    if_req = 1; if_addr = 32'h300; c0 = cyc;
    expect_acc(c0, 0, 0, 32'h300, 0, 0, W, 0);
    tick(); tick();
    if_req = 0;
    tick(); tick(); tick();
    vectors++;
    if (if_rdata != f(32'h200)) begin
      miscompares++;
      $display("FAIL flush_rdata got %h want %h", if_rdata, f(32'h200));
    end
    MEM_R = 1; mem_addr = 32'h4C; c0 = cyc;
    expect_acc(c0, 1, 0, 32'h4C, 0, f(32'h4C), W, 1);
    drain();
    MEM_W = 1; mem_addr = 32'h88; mem_wdata = 32'hCAFEF00D; c0 = cyc;
    expect_acc(c0, 1, 1, 32'h88, 32'hCAFEF00D, 0, 2, 0);
    tick(); tick();
    rst = 1; MEM_W = 0;
    tick();
    rst = 0;
    vectors++;
    if (sram_en || sram_we || mem_ready) begin
      miscompares++;
      $display("FAIL reset_mid got en=%b we=%b rdy=%b want 0 0 0", sram_en, sram_we, mem_ready);
    end
    tick(); tick(); tick();
    MEM_R = 1; mem_addr = 32'h40; c0 = cyc;
    expect_acc(c0, 1, 0, 32'h40, 0, 32'hDEADBEEF, W, 1);
    drain();
    tick(); tick();
    vectors++;
    if (exp_acc.size() != 0 || exp_rsp.size() != 0) begin
      miscompares++;
      $display("FAIL leftover got acc=%0d rsp=%0d want 0 0", exp_acc.size(), exp_rsp.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
